// File: rtl/boss_pkg.sv
// Shared constants and types for the boss sprite reader: sprite geometry,
// special palette indices and the damage-flash state encoding.
package boss_pkg;
  localparam int BOSS_W     = 185;
  localparam int BOSS_H     = 150;
  localparam int BOSS_DEPTH = 27750;
  localparam int ADDR_W     = 19;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
  localparam logic [3:0] FLASH_IDX       = 4'hF;
  localparam logic [4:0] FLASH_FRAMES    = 5'd16;

  typedef enum logic {
    ST_IDLE,
    ST_FLASH
  } flash_state_t;
endpackage

// File: rtl/boss_addr_gen.sv
// Stage 1 of the sprite pipeline: box hit test against the shadowed sprite
// position and registered sprite RAM address (row*BOSS_W + col).
module boss_addr_gen
  import boss_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        i_draw_x,
  input  logic [9:0]        i_draw_y,
  input  logic              i_pixel_valid,
  input  logic [9:0]        i_sx,
  input  logic [9:0]        i_sy,
  input  logic              i_flip,
  output logic [ADDR_W-1:0] o_read_address,
  output logic              o_hit
);

  logic              w_in_x;
  logic              w_in_y;
  logic              w_hit;
  logic [7:0]        w_dx;
  logic [7:0]        w_dy;
  logic [7:0]        w_col;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_read_address;
  logic              r_hit;

  // 11-bit compare so a sprite near x=1023 cannot wrap its right edge to 0.
  assign w_in_x = ({1'b0, i_draw_x} >= {1'b0, i_sx}) &&
                  ({1'b0, i_draw_x} <  ({1'b0, i_sx} + 11'(BOSS_W)));
  assign w_in_y = ({1'b0, i_draw_y} >= {1'b0, i_sy}) &&
                  ({1'b0, i_draw_y} <  ({1'b0, i_sy} + 11'(BOSS_H)));
  assign w_hit  = i_pixel_valid && w_in_x && w_in_y;

  assign w_dx   = 8'(i_draw_x - i_sx);
  assign w_dy   = 8'(i_draw_y - i_sy);
  assign w_col  = i_flip ? (8'(BOSS_W - 1) - w_dx) : w_dx;
  assign w_addr = ADDR_W'(w_dy) * ADDR_W'(BOSS_W) + ADDR_W'(w_col);

  // NOTE: non-blocking assignments in the clocked block; the async reset
  // clears the pipeline the moment Reset rises, not at the next edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_read_address <= '0;
      r_hit          <= 1'b0;
    end else begin
      r_hit <= w_hit;
      if (w_hit) r_read_address <= w_addr;
    end
  end

  assign o_read_address = r_read_address;
  assign o_hit          = r_hit;

endmodule

// File: rtl/boss_sprite_reader.sv
// Boss sprite reader: frame-synchronous position shadowing, two-stage pixel
// pipeline into the sprite RAM, transparency and damage-flash recolouring.
module boss_sprite_reader
  import boss_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pixel_valid,
  input  logic              frame_start,
  input  logic [9:0]        boss_x,
  input  logic [9:0]        boss_y,
  input  logic              flip,
  input  logic              hit_pulse,
  input  logic [3:0]        ram_data,
  output logic [ADDR_W-1:0] read_address,
  output logic              is_boss,
  output logic [3:0]        palette_idx,
  output logic              flashing
);

  logic [9:0]   r_sx;
  logic [9:0]   r_sy;
  logic         r_flip;
  logic         r_hit2;
  flash_state_t r_state;
  logic [4:0]   r_count;
  logic         w_hit1;
  logic         w_flash_on;

  // Position only moves at frame boundaries so a frame is never torn.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_flip <= 1'b0;
    end else if (frame_start) begin
      r_sx   <= boss_x;
      r_sy   <= boss_y;
      r_flip <= flip;
    end
  end

  boss_addr_gen u_addr_gen (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_draw_x       (DrawX),
    .i_draw_y       (DrawY),
    .i_pixel_valid  (pixel_valid),
    .i_sx           (r_sx),
    .i_sy           (r_sy),
    .i_flip         (r_flip),
    .o_read_address (read_address),
    .o_hit          (w_hit1)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_hit2 <= 1'b0;
    else       r_hit2 <= w_hit1;
  end

  // A new hit always restarts the flash, even on a frame_start cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else if (hit_pulse) begin
      r_state <= ST_FLASH;
      r_count <= FLASH_FRAMES;
    end else if (r_state == ST_FLASH && frame_start) begin
      if (r_count == 5'd1) begin
        r_state <= ST_IDLE;
        r_count <= '0;
      end else begin
        r_count <= r_count - 5'd1;
      end
    end
  end

  assign w_flash_on = (r_state == ST_FLASH) && r_count[0];
  assign flashing   = (r_state == ST_FLASH);
  assign is_boss    = r_hit2 && (ram_data != TRANSPARENT_IDX);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    palette_idx = TRANSPARENT_IDX;
    if (is_boss) palette_idx = w_flash_on ? FLASH_IDX : ram_data;
  end

endmodule
